// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular FIFO of {addr, instr} entries between the
// instruction memory and decode, with PC hold when full and flush on branch.
module fetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          fetch_valid_i,
    input  logic [15:0]   addr_imem_i,
    input  logic [15:0]   instr_i,
    input  logic          flush_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [15:0]   instr_o,
    output logic [15:0]   pc_o,
    output logic          pc_stall_no,
    output logic [AW:0]   count_o
);
    // Pointers are sized to the array so they wrap modulo DEPTH naturally;
    // AW only sets the width of the occupancy count.
    localparam int unsigned PW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [AW:0]   cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [31:0]   head;

    always_comb begin
        full  = (cnt == FULL_CNT);
        empty = (cnt == '0);
        push  = fetch_valid_i & ~full & ~flush_i;
        pop   = ~empty & ready_i & ~flush_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {addr_imem_i, instr_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_comb begin
        head        = mem[rd_ptr];
        valid_o     = ~empty;
        pc_o        = head[31:16];
        instr_o     = head[15:0];
        pc_stall_no = ~full;
        count_o     = cnt;
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH 4): reset, fill, stream,
// flush, full-with-pop and 16-bit PC wrap, checked with immediate assertions.
module tb_fetch_buffer;
    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [15:0] addr_imem;
    logic [15:0] instr;
    logic        flush;
    logic        ready;
    logic        valid;
    logic [15:0] instr_out;
    logic [15:0] pc;
    logic        pc_stall_n;
    logic [2:0]  count;

    int unsigned n_checks;
    int unsigned n_fail;

    fetch_buffer #(.DEPTH(4), .AW(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .fetch_valid_i (fetch_valid),
        .addr_imem_i   (addr_imem),
        .instr_i       (instr),
        .flush_i       (flush),
        .ready_i       (ready),
        .valid_o       (valid),
        .instr_o       (instr_out),
        .pc_o          (pc),
        .pc_stall_no   (pc_stall_n),
        .count_o       (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [15:0] a, input logic [15:0] d, input logic rdy);
        fetch_valid = fv;
        addr_imem   = a;
        instr       = d;
        ready       = rdy;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);

        // power-on reset
        #3;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_stall_n", 32'(pc_stall_n), 32'd1);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_instr", 32'(instr_out), 32'h0);
        #9;
        rst_n = 1'b1;

        // first push right after release, then queue 3 entries
        drive(1'b1, 16'h0000, 16'h1234, 1'b0);
        tick();
        check("post_rst_valid", 32'(valid), 32'd1);
        check("post_rst_pc", 32'(pc), 32'h0000);
        check("post_rst_instr", 32'(instr_out), 32'h1234);
        drive(1'b1, 16'h0001, 16'h1111, 1'b0);
        tick();
        drive(1'b1, 16'h0002, 16'h2222, 1'b0);
        tick();
        check("pre_rst_count", 32'(count), 32'd3);

        // asynchronous reset mid-cycle with 3 queued
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(valid), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_stall_n", 32'(pc_stall_n), 32'd1);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 16'h0000, 16'h1234, 1'b0);
        tick();
        check("rel_valid", 32'(valid), 32'd1);
        check("rel_pc", 32'(pc), 32'h0000);
        check("rel_instr", 32'(instr_out), 32'h1234);
        check("rel_count", 32'(count), 32'd1);
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        check("rel_drain_count", 32'(count), 32'd0);
        check("rel_drain_valid", 32'(valid), 32'd0);

        // fill to full with ready low
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(16'h0010 + i), 16'(16'hA000 + i), 1'b0);
            tick();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_stall_n", 32'(pc_stall_n), 32'd0);
        drive(1'b1, 16'h0014, 16'hA004, 1'b0);
        tick();
        check("full_ignore_count", 32'(count), 32'd4);
        check("full_head_stable", 32'(pc), 32'h0010);
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", 32'(pc), 32'(16'h0010 + i));
            check("drain_instr", 32'(instr_out), 32'(16'hA000 + i));
            tick();
            if (i == 0) begin
                check("unfull_stall_n", 32'(pc_stall_n), 32'd1);
                check("unfull_count", 32'(count), 32'd3);
            end
        end
        check("drain_empty", 32'(valid), 32'd0);

        // streaming: one push and one pop per cycle across several wraps
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'(16'h0100 + i), 16'(16'hB000 + i), 1'b1);
            tick();
            check("stream_count", 32'(count), 32'd1);
            check("stream_pc", 32'(pc), 32'(16'h0100 + i));
            check("stream_instr", 32'(instr_out), 32'(16'hB000 + i));
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        check("stream_end_count", 32'(count), 32'd0);

        // flush with 3 queued, concurrent fetch and ready
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(16'h0020 + i), 16'(16'hC000 + i), 1'b0);
            tick();
        end
        check("preflush_count", 32'(count), 32'd3);
        drive(1'b1, 16'h0200, 16'hC200, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(valid), 32'd0);
        drive(1'b1, 16'h0040, 16'hD040, 1'b0);
        tick();
        check("postflush_count", 32'(count), 32'd1);
        check("postflush_pc", 32'(pc), 32'h0040);
        check("postflush_instr", 32'(instr_out), 32'hD040);
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        check("postflush_drain", 32'(count), 32'd0);

        // full with simultaneous pop: push blocked, re-presented next cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(16'h0030 + i), 16'(16'hE000 + i), 1'b0);
            tick();
        end
        check("fp_full_stall_n", 32'(pc_stall_n), 32'd0);
        drive(1'b1, 16'h0300, 16'hF300, 1'b1);
        tick();
        check("fp_count", 32'(count), 32'd3);
        check("fp_stall_n", 32'(pc_stall_n), 32'd1);
        check("fp_head", 32'(pc), 32'h0031);
        drive(1'b1, 16'h0300, 16'hF300, 1'b0);
        tick();
        check("fp_refill_count", 32'(count), 32'd4);
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        check("fp_order0", 32'(pc), 32'h0031);
        tick();
        check("fp_order1", 32'(pc), 32'h0032);
        tick();
        check("fp_order2", 32'(pc), 32'h0033);
        tick();
        check("fp_order3_pc", 32'(pc), 32'h0300);
        check("fp_order3_instr", 32'(instr_out), 32'hF300);
        tick();
        check("fp_empty", 32'(count), 32'd0);

        // 16-bit PC wrap
        drive(1'b1, 16'hFFFE, 16'h0EEE, 1'b0);
        tick();
        drive(1'b1, 16'h0000, 16'h0FFF, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        check("wrap_count", 32'(count), 32'd2);
        check("wrap_pc0", 32'(pc), 32'hFFFE);
        check("wrap_instr0", 32'(instr_out), 32'h0EEE);
        ready = 1'b1;
        tick();
        check("wrap_pc1", 32'(pc), 32'h0000);
        check("wrap_instr1", 32'(instr_out), 32'h0FFF);
        tick();
        check("wrap_empty", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
